// File: rtl/lcd_capture.sv
// lcd_capture: captures an RGB/HS/VS/DE LCD stream into addressed pixel writes with timing checks.
// Defining LCD_CAPTURE_CRC_EN adds a per-frame CRC-16-CCITT on oFrameCRC; otherwise it is tied to 0.
module lcd_capture #(
    parameter int unsigned H_ACT = 800,
    parameter int unsigned V_ACT = 480
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [7:0]  iLCD_R,
    input  logic [7:0]  iLCD_G,
    input  logic [7:0]  iLCD_B,
    input  logic        iLCD_HS,
    input  logic        iLCD_VS,
    input  logic        iLCD_DE,
    output logic [23:0] oPixel,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic [21:0] oAddress,
    output logic        oWrite,
    output logic        oFrameDone,
    output logic        oLocked,
    output logic        oErr,
    output logic [15:0] oFrameCRC
);
    localparam int unsigned RUN_W  = $clog2(H_ACT + 2);
    localparam int unsigned LINE_W = $clog2(V_ACT + 1);
    localparam int unsigned ADDR_W = 22;

    typedef enum logic [1:0] {SEARCH, VSYNC, FRAME} state_t;

    state_t            r_state;
    logic [7:0]        r_r, r_g, r_b;
    logic              r_hs, r_vs, r_de, r_vs_d, r_de_d;
    logic [RUN_W-1:0]  r_run;
    logic [LINE_W-1:0] r_line;
    logic              w_vs_fall, w_vs_rise, w_de_fall, w_run_full, w_run_sat;

    assign w_vs_fall  = r_vs_d & ~r_vs;
    assign w_vs_rise  = ~r_vs_d & r_vs;
    assign w_de_fall  = r_de_d & ~r_de;
    assign w_run_full = (r_run == RUN_W'(H_ACT));
    assign w_run_sat  = (r_run == RUN_W'(H_ACT + 1));

`ifdef LCD_CAPTURE_CRC_EN
    logic [15:0] r_crc;

    // CRC-16-CCITT over 24 bits, MSB first
    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] v;
        v = c;
        for (int i = 23; i >= 0; i--) begin
            v = {v[14:0], 1'b0} ^ ((v[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return v;
    endfunction
`else
    assign oFrameCRC = 16'h0000;
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state    <= SEARCH;
            r_r        <= '0;
            r_g        <= '0;
            r_b        <= '0;
            r_hs       <= 1'b0;
            r_vs       <= 1'b0;
            r_de       <= 1'b0;
            r_vs_d     <= 1'b0;
            r_de_d     <= 1'b0;
            r_run      <= '0;
            r_line     <= '0;
            oPixel     <= '0;
            oX         <= '0;
            oY         <= '0;
            oAddress   <= '0;
            oWrite     <= 1'b0;
            oFrameDone <= 1'b0;
            oLocked    <= 1'b0;
            oErr       <= 1'b0;
`ifdef LCD_CAPTURE_CRC_EN
            r_crc      <= 16'hFFFF;
            oFrameCRC  <= '0;
`endif
        end else begin
            r_r        <= iLCD_R;
            r_g        <= iLCD_G;
            r_b        <= iLCD_B;
            r_hs       <= iLCD_HS;
            r_vs       <= iLCD_VS;
            r_de       <= iLCD_DE;
            r_vs_d     <= r_vs;
            r_de_d     <= r_de;
            oWrite     <= 1'b0;
            oFrameDone <= 1'b0;
            oErr       <= 1'b0;
`ifdef LCD_CAPTURE_CRC_EN
            if (w_vs_rise) begin
                r_crc <= 16'hFFFF;
            end
`endif
            case (r_state)
                SEARCH: begin
                    r_run <= '0;
                    if (w_vs_fall) begin
                        r_state <= VSYNC;
                    end
                end
                VSYNC: begin
                    r_run <= '0;
                    if (r_de) begin
                        oErr    <= 1'b1;
                        oLocked <= 1'b0;
                        r_state <= SEARCH;
                    end else if (w_vs_rise) begin
                        r_line  <= '0;
                        r_state <= FRAME;
                    end
                end
                FRAME: begin
                    if (w_vs_fall) begin
                        oErr    <= 1'b1;
                        oLocked <= 1'b0;
                        r_state <= VSYNC;
                    end else if (r_de) begin
                        r_run <= w_run_sat ? r_run : RUN_W'(r_run + 1'b1);
                        // overlong run is flagged on its extra pixel, not at DE fall
                        if (!r_hs || w_run_full) begin
                            oErr    <= 1'b1;
                            oLocked <= 1'b0;
                            r_state <= SEARCH;
                        end else begin
                            oWrite   <= 1'b1;
                            oPixel   <= {r_r, r_g, r_b};
                            oX       <= 10'(r_run);
                            oY       <= 10'(r_line);
                            oAddress <= ADDR_W'(r_line) * ADDR_W'(H_ACT) + ADDR_W'(r_run);
`ifdef LCD_CAPTURE_CRC_EN
                            r_crc    <= crc_upd(r_crc, {r_r, r_g, r_b});
`endif
                        end
                    end else begin
                        r_run <= '0;
                        if (w_de_fall) begin
                            if (!w_run_full) begin
                                oErr    <= 1'b1;
                                oLocked <= 1'b0;
                                r_state <= SEARCH;
                            end else if (r_line == LINE_W'(V_ACT - 1)) begin
                                oFrameDone <= 1'b1;
                                oLocked    <= 1'b1;
                                r_line     <= LINE_W'(r_line + 1'b1);
`ifdef LCD_CAPTURE_CRC_EN
                                oFrameCRC  <= r_crc;
`endif
                                r_state    <= SEARCH;
                            end else begin
                                r_line <= LINE_W'(r_line + 1'b1);
                            end
                        end
                    end
                end
                default: r_state <= SEARCH;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_capture.sv
// tb_lcd_capture: random-pixel LCD frames against a queue-based reference model; a monitor
// pops expected write/done/error events whenever the DUT emits one.
module tb_lcd_capture;
    localparam int unsigned H = 16;
    localparam int unsigned V = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  iLCD_R = '0, iLCD_G = '0, iLCD_B = '0;
    logic        iLCD_HS = 1'b1, iLCD_VS = 1'b1, iLCD_DE = 1'b0;
    logic [23:0] oPixel;
    logic [9:0]  oX, oY;
    logic [21:0] oAddress;
    logic        oWrite, oFrameDone, oLocked, oErr;
    logic [15:0] oFrameCRC;

    always #5 clk = ~clk;

    lcd_capture #(.H_ACT(H), .V_ACT(V)) dut (
        .iCLK(clk), .iRST_N(rst_n),
        .iLCD_R(iLCD_R), .iLCD_G(iLCD_G), .iLCD_B(iLCD_B),
        .iLCD_HS(iLCD_HS), .iLCD_VS(iLCD_VS), .iLCD_DE(iLCD_DE),
        .oPixel(oPixel), .oX(oX), .oY(oY), .oAddress(oAddress),
        .oWrite(oWrite), .oFrameDone(oFrameDone), .oLocked(oLocked),
        .oErr(oErr), .oFrameCRC(oFrameCRC)
    );

    // kind: 0 write, 1 frame done, 2 error
    typedef struct {
        int          kind;
        int          x;
        int          y;
        logic [23:0] pix;
        logic [15:0] crc;
    } ev_t;

    ev_t         exp_q[$];
    logic [23:0] m_pix[$];
    bit          m_cap = 1'b0;
    bit          m_locked = 1'b0;
    int          m_line = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    ev_t         got;
    int          got_kind;

    function automatic void push_ev(input int k, input int x, input int y, input logic [23:0] p, input logic [15:0] c);
        ev_t e;
        e.kind = k; e.x = x; e.y = y; e.pix = p; e.crc = c;
        exp_q.push_back(e);
    endfunction

    // CRC-16-CCITT (0x1021, init 0xFFFF) over the frame's written pixels, 24 bits each MSB first
    function automatic logic [15:0] frame_crc();
        logic [15:0] c;
        bit          fb;
        c = 16'hFFFF;
        foreach (m_pix[n]) begin
            for (int b = 23; b >= 0; b--) begin
                fb = c[15] ^ m_pix[n][b];
                c  = c << 1;
                if (fb) c = c ^ 16'h1021;
            end
        end
`ifdef LCD_CAPTURE_CRC_EN
        return c;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_oPixel"},     32'(oPixel),     32'h0);
        chk({tag, "_oX"},         32'(oX),         32'h0);
        chk({tag, "_oY"},         32'(oY),         32'h0);
        chk({tag, "_oAddress"},   32'(oAddress),   32'h0);
        chk({tag, "_oWrite"},     32'(oWrite),     32'h0);
        chk({tag, "_oFrameDone"}, 32'(oFrameDone), 32'h0);
        chk({tag, "_oLocked"},    32'(oLocked),    32'h0);
        chk({tag, "_oErr"},       32'(oErr),       32'h0);
        chk({tag, "_oFrameCRC"},  32'(oFrameCRC),  32'h0);
    endtask

    task automatic drive(input logic vs, input logic hs, input logic de, input logic [23:0] p);
        iLCD_VS = vs;
        iLCD_HS = hs;
        iLCD_DE = de;
        {iLCD_R, iLCD_G, iLCD_B} = p;
        @(negedge clk);
    endtask

    // one line: HS pulse, back porch, DE run of len pixels, front porch
    task automatic run_line(input int len, input int hs_bad, input int mode, input int y, input int rst_px);
        logic [23:0] p;
        drive(1'b1, 1'b0, 1'b0, 24'h0);
        drive(1'b1, 1'b0, 1'b0, 24'h0);
        drive(1'b1, 1'b1, 1'b0, 24'h0);
        drive(1'b1, 1'b1, 1'b0, 24'h0);
        for (int i = 0; i < len; i++) begin
            case (mode)
                1:       p = 24'h0;
                2:       p = (i == 0 && y == 0) ? 24'hFFFFFF : 24'h0;
                default: p = 24'($urandom);
            endcase
            if (rst_px >= 0 && i == rst_px) begin
                // the previous pixel is still in the pipeline and is lost to the reset
                if (m_cap && i > 0) exp_q.pop_back();
                m_cap = 1'b0;
                m_locked = 1'b0;
                rst_n = 1'b0;
                #1;
                check_zero("midrst");
            end
            if (rst_px >= 0 && i == rst_px + 3) rst_n = 1'b1;
            if (m_cap) begin
                if (i == hs_bad || i >= int'(H)) begin
                    push_ev(2, 0, 0, 24'h0, 16'h0);
                    m_cap = 1'b0;
                    m_locked = 1'b0;
                end else begin
                    push_ev(0, i, m_line, p, 16'h0);
                    m_pix.push_back(p);
                end
            end
            drive(1'b1, (i == hs_bad) ? 1'b0 : 1'b1, 1'b1, p);
        end
        if (m_cap) begin
            if (len != int'(H)) begin
                push_ev(2, 0, 0, 24'h0, 16'h0);
                m_cap = 1'b0;
                m_locked = 1'b0;
            end else begin
                m_line++;
                if (m_line == int'(V)) begin
                    push_ev(1, 0, 0, 24'h0, frame_crc());
                    m_cap = 1'b0;
                    m_locked = 1'b1;
                end
            end
        end
        repeat (3) drive(1'b1, 1'b1, 1'b0, 24'h0);
    endtask

    task automatic run_frame(input int nlines, input int short_y, input int short_len, input int hs_y,
                             input bit de_vs, input int mode, input int rst_y, input int rst_px);
        if (m_cap) begin
            push_ev(2, 0, 0, 24'h0, 16'h0);
            m_cap = 1'b0;
            m_locked = 1'b0;
        end
        if (de_vs) begin
            push_ev(2, 0, 0, 24'h0, 16'h0);
            m_locked = 1'b0;
        end
        for (int k = 0; k < 6; k++) drive(1'b0, 1'b1, de_vs && k >= 2 && k < 4, 24'h0);
        m_cap = !de_vs;
        m_line = 0;
        m_pix.delete();
        repeat (3) drive(1'b1, 1'b1, 1'b0, 24'h0);
        for (int y = 0; y < nlines; y++) begin
            run_line((y == short_y) ? short_len : int'(H), (y == hs_y) ? 3 : -1, mode, y,
                     (y == rst_y) ? rst_px : -1);
        end
        repeat (4) drive(1'b1, 1'b1, 1'b0, 24'h0);
        chk("locked", 32'(oLocked), 32'(m_locked));
    endtask

    // monitor: every DUT event must match the next expected one
    always @(posedge clk) begin
        #1;
        if (rst_n && (oWrite || oFrameDone || oErr)) begin
            got_kind = oWrite ? 0 : (oFrameDone ? 1 : 2);
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got kind %0d at x=%0d y=%0d, want none", got_kind, oX, oY);
            end else begin
                got = exp_q.pop_front();
                if (got_kind != got.kind) begin
                    n_bad++;
                    $display("FAIL event_kind: got %0d want %0d (want x=%0d y=%0d)", got_kind, got.kind, got.x, got.y);
                end else if (got.kind == 0 &&
                             (oX !== 10'(got.x) || oY !== 10'(got.y) ||
                              oAddress !== 22'(got.y * int'(H) + got.x) || oPixel !== got.pix)) begin
                    n_bad++;
                    $display("FAIL write: got x=%0d y=%0d a=%0d p=%06h want x=%0d y=%0d a=%0d p=%06h",
                             oX, oY, oAddress, oPixel, got.x, got.y, got.y * int'(H) + got.x, got.pix);
                end else if (got.kind == 1 && oFrameCRC !== got.crc) begin
                    n_bad++;
                    $display("FAIL frame_crc: got %04h want %04h", oFrameCRC, got.crc);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) drive(1'b1, 1'b1, 1'b0, 24'h0);
        run_line(int'(H) - 3, -1, 0, 0, -1);          // DE before alignment is ignored
        run_frame(V, -1, 0, -1, 1'b0, 0, -1, -1);     // nominal, locks
        run_frame(V, -1, 0, -1, 1'b0, 0, -1, -1);
        run_frame(V, 3, int'(H) - 1, -1, 1'b0, 0, -1, -1);  // short line
        run_frame(V, -1, 0, -1, 1'b0, 0, -1, -1);
        run_frame(V, 5, int'(H) + 1, -1, 1'b0, 0, -1, -1);  // long line
        run_frame(V, -1, 0, -1, 1'b0, 0, -1, -1);
        run_frame(5, -1, 0, -1, 1'b0, 0, -1, -1);     // early VS on the next frame
        run_frame(V, -1, 0, -1, 1'b0, 0, -1, -1);
        run_frame(V, -1, 0, 2, 1'b0, 0, -1, -1);      // HS low during DE
        run_frame(V, -1, 0, -1, 1'b0, 0, -1, -1);
        run_frame(V, -1, 0, -1, 1'b1, 0, -1, -1);     // DE while VS low
        run_frame(V, -1, 0, -1, 1'b0, 0, -1, -1);
        run_frame(V, -1, 0, -1, 1'b0, 0, 4, 6);       // reset mid-line
        run_frame(V, -1, 0, -1, 1'b0, 0, -1, -1);
        run_frame(V, -1, 0, -1, 1'b0, 1, -1, -1);     // all-zero frame
        run_frame(V, -1, 0, -1, 1'b0, 2, -1, -1);     // zero frame with white corner
        repeat (10) drive(1'b1, 1'b1, 1'b0, 24'h0);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/lcd_capture.md
LCD_CAPTURE -- requirements
Module: lcd_capture

Interface
REQ-001 Parameter H_ACT, default 800, SHALL set the active pixels per line.
REQ-002 Parameter V_ACT, default 480, SHALL set the active lines per frame.
REQ-003 iCLK  input  1  pixel clock; all inputs are synchronous to it.
REQ-004 iRST_N  input  1  reset, asynchronous, active-low.
REQ-005 iLCD_R, iLCD_G, iLCD_B  input  8 each  pixel color.
REQ-006 iLCD_HS  input  1  horizontal sync, active-low.
REQ-007 iLCD_VS  input  1  vertical sync, active-low.
REQ-008 iLCD_DE  input  1  data enable, active-high.
REQ-009 oPixel  output  24  captured {R,G,B}.
REQ-010 oX, oY  output  10 each  coordinate of oPixel.
REQ-011 oAddress  output  22  oY*H_ACT+oX.
REQ-012 oWrite  output  1  oPixel, oX, oY and oAddress are valid this cycle.
REQ-013 oFrameDone  output  1  one-cycle pulse after the last pixel of a frame.
REQ-014 oLocked  output  1  a complete error-free frame has been seen since the last error.
REQ-015 oErr  output  1  one-cycle pulse on any timing violation.
REQ-016 oFrameCRC  output  16  CRC of the last completed frame (see Configuration).

Function
REQ-017 Clock and reset SHALL be: reset iRST_N, asynchronous, active-low; clock iCLK.
REQ-018 The block SHALL register all inputs once, then detect edges on the registered copies.
REQ-019 States SHALL be SEARCH, VSYNC, FRAME.
- SEARCH: wait for a VS falling edge, then go to VSYNC.
- VSYNC: wait for a VS rising edge, clear the line counter, then go to FRAME.
- FRAME: capture pixels.
REQ-020 In FRAME, each registered DE=1 cycle SHALL produce oWrite=1 exactly one cycle later, with oX = run index (0..H_ACT-1) and oY = line counter.
- The pixel-to-oWrite latency is therefore 2 iCLK from the input pins.
REQ-021 On each DE falling edge in FRAME:
- a run length of exactly H_ACT SHALL increment the line counter;
- any other length SHALL be an error.
REQ-022 When the line counter reaches V_ACT, the block SHALL pulse oFrameDone (coincident with the final oWrite+1 cycle) and go to SEARCH.
REQ-023 Error conditions:
- a DE run longer than H_ACT (flagged at pixel H_ACT+1, without waiting for DE fall);
- a DE run shorter than H_ACT;
- a VS falling edge in FRAME before V_ACT lines;
- DE=1 while in VSYNC.
REQ-024 On any error, the block SHALL:
- pulse oErr;
- clear oLocked;
- suppress oWrite from that cycle on.
If the error was a VS falling edge, the next state SHALL be VSYNC; otherwise it SHALL be SEARCH.
REQ-025 oLocked SHALL set on oFrameDone and clear only on an error or reset.
REQ-026 DE=1 in SEARCH SHALL be ignored without raising an error, because it occurs at start-up before alignment.
REQ-027 HS SHALL NOT affect capture. HS low while DE=1 SHALL be an error.
REQ-028 oAddress SHALL be computed with 22-bit unsigned arithmetic and SHALL be registered with oWrite.
REQ-029 The run counter SHALL saturate at H_ACT+1 and SHALL NOT wrap.

Reset
REQ-030 During reset the following SHALL be 0: oPixel, oX, oY, oAddress, oWrite, oFrameDone, oLocked, oErr, oFrameCRC. The state SHALL be SEARCH and the counters SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL abort capture immediately. Capture SHALL resume only after a full VS low/high sequence.

Configuration
REQ-032 With LCD_CAPTURE_CRC_EN defined:
- a CRC-16-CCITT (poly 0x1021, init 0xFFFF) SHALL be updated over the 24 bits of each written pixel;
- it SHALL be latched to oFrameCRC on oFrameDone and re-initialised at the VS rising edge.
REQ-033 Without LCD_CAPTURE_CRC_EN, oFrameCRC SHALL be constant 0 and no CRC logic SHALL be synthesised.

Verification
REQ-034 Nominal: 992x500 timing source, front porches 24/3, syncs 72/10, gradient R=x[7:0], G=y[7:0] -> 384000 oWrite pulses, last at oX=799, oY=479, oAddress=383999; oFrameDone once; oLocked=1 after frame 1.
REQ-035 Short line: line 100 has 799 DE cycles -> oErr pulse at that DE fall; oLocked=0; no oWrite until the next VS; the following clean frame relocks.
REQ-036 Long line: line 5 has 801 DE cycles -> oErr on the 801st pixel cycle; no write for pixel 800.
REQ-037 Early VS: VS falls after 300 lines -> oErr; state VSYNC; the next frame is captured fully with oY restarting at 0.
REQ-038 Reset pulse mid-line (oY=200, oX=400) -> all outputs 0 within the reset; DE activity ignored until after the next VS rising edge.
REQ-039 With LCD_CAPTURE_CRC_EN: all-zero frame, then one with pixel (0,0)=0xFFFFFF -> the oFrameCRC values differ and match the reference model. Without the macro -> oFrameCRC=0.
